// File: rtl/lyra2_result_unloader.sv
// Lyra2 result unloader: collects one batch of PIPELINE_STAGES wide core
// results, then streams them out as OUT_WIDTH words (LS word first, slot 0
// first). The core is held off (res_ready=0) until the batch is fully drained.
module lyra2_result_unloader #(
    parameter int PIPELINE_STAGES = 8,
    parameter int DATA_WIDTH      = 256,
    parameter int OUT_WIDTH       = 64,
    localparam int BEATS  = DATA_WIDTH / OUT_WIDTH,
    localparam int SLOT_W = (PIPELINE_STAGES > 1) ? $clog2(PIPELINE_STAGES) : 1,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_res_valid,
    input  logic [DATA_WIDTH-1:0] i_res_data,
    output logic                  o_res_ready,
    output logic                  o_m_valid,
    output logic [OUT_WIDTH-1:0]  o_m_data,
    output logic                  o_m_last,
    output logic [SLOT_W-1:0]     o_m_slot,
    input  logic                  i_m_ready,
    output logic                  o_batch_done,
    output logic                  o_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SLOT_W-1:0]     r_wr_cnt;
    logic [SLOT_W-1:0]     r_rd_slot;
    logic [BEAT_W-1:0]     r_rd_beat;
    logic                  r_batch_done;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_buf [PIPELINE_STAGES];

    logic                  w_res_ready;
    logic                  w_m_valid;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_last_beat;
    logic                  w_last_slot;
    logic                  w_last_wr;
    logic                  w_final;
    logic [OUT_WIDTH-1:0]  w_word;

    assign w_accept    = i_res_valid & w_res_ready;
    assign w_xfer      = w_m_valid & i_m_ready;
    assign w_last_beat = (r_rd_beat == BEAT_W'(BEATS - 1));
    assign w_last_slot = (r_rd_slot == SLOT_W'(PIPELINE_STAGES - 1));
    assign w_last_wr   = (r_wr_cnt == SLOT_W'(PIPELINE_STAGES - 1));
    assign w_final     = w_xfer & w_last_beat & w_last_slot;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus the state-decoded handshake outputs (depend on state only)
    always_comb begin
        w_state_nxt = r_state;
        w_res_ready = 1'b0;
        w_m_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_res_ready = 1'b1;
                if (i_res_valid)
                    w_state_nxt = (PIPELINE_STAGES == 1) ? S_DRAIN : S_COLLECT;
            end
            S_COLLECT: begin
                w_res_ready = 1'b1;
                if (i_res_valid && w_last_wr) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_m_valid = 1'b1;
                if (w_final) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write slot and read slot/beat counters; all wrap to 0 at batch boundaries
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_cnt  <= '0;
            r_rd_slot <= '0;
            r_rd_beat <= '0;
        end else begin
            if (w_accept)
                r_wr_cnt <= w_last_wr ? '0 : r_wr_cnt + SLOT_W'(1);
            if (w_xfer) begin
                if (w_last_beat) begin
                    r_rd_beat <= '0;
                    r_rd_slot <= w_last_slot ? '0 : r_rd_slot + SLOT_W'(1);
                end else begin
                    r_rd_beat <= r_rd_beat + BEAT_W'(1);
                end
            end
        end
    end

    // Batch-done pulse and sticky overflow (writes while not ready are dropped)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_batch_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_batch_done <= w_final;
            r_overflow   <= r_overflow | (i_res_valid & ~w_res_ready);
        end
    end

    // Result buffer; contents need no reset since reads are gated by state
    always_ff @(posedge i_clk) begin
        if (w_accept) r_buf[r_wr_cnt] <= i_res_data;
    end

    // Select the current beat of the current slot
    always_comb begin
        w_word = '0;
        for (int b = 0; b < BEATS; b++)
            if (r_rd_beat == BEAT_W'(b))
                w_word = r_buf[r_rd_slot][b*OUT_WIDTH +: OUT_WIDTH];
    end

    assign o_res_ready  = w_res_ready;
    assign o_m_valid    = w_m_valid;
    assign o_m_data     = w_m_valid ? w_word : '0;
    assign o_m_last     = w_m_valid & w_last_beat;
    assign o_m_slot     = w_m_valid ? r_rd_slot : '0;
    assign o_batch_done = r_batch_done;
    assign o_overflow   = r_overflow;

endmodule

// File: doc/lyra2_result_unloader.md
Name: lyra2_result_unloader

Overview:
- Sits at the output side of the Lyra2 pipelined core, on the opposite end of the core's data path from the input loader.
- Captures the LYRA2_PIPELINE_STAGES results that one computing batch produces, each LYRA2_OUTPUT_DATA_WIDTH bits wide.
- Buffers them and drains them as narrow words on a valid/ready stream toward the host interface.
- Applies flow control to the core so that a new batch can only be delivered once the previous batch has been fully drained.

Parameters:
- PIPELINE_STAGES, 8, number of results per batch (matches LYRA2_PIPELINE_STAGES).
- DATA_WIDTH, 256, width of one core result (matches LYRA2_OUTPUT_DATA_WIDTH).
- OUT_WIDTH, 64, width of the output stream word; DATA_WIDTH must be an integer multiple of OUT_WIDTH.
- Derived: BEATS = DATA_WIDTH/OUT_WIDTH (4); TOTAL = PIPELINE_STAGES*BEATS (32).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- res_valid  in  1  core presents one result this cycle.
- res_data  in  DATA_WIDTH  core result.
- res_ready  out  1  unloader can accept results (state is IDLE or COLLECT).
- m_valid  out  1  output word valid.
- m_data  out  OUT_WIDTH  output word.
- m_last  out  1  final word of the current result.
- m_slot  out  clog2(PIPELINE_STAGES)  pipeline slot index of the current word.
- m_ready  in  1  downstream accepts word.
- batch_done  out  1  one-cycle pulse after the final word of the batch is accepted.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst_n=0) values:
  - state=IDLE, all counters 0.
  - res_ready=1.
  - m_valid=0, m_data=0, m_last=0, m_slot=0.
  - batch_done=0, overflow=0.
  - Buffer contents are don't-care.
- Storage: PIPELINE_STAGES x DATA_WIDTH register buffer; write slot counter wr_cnt; read counters rd_slot and rd_beat.
- IDLE:
  - res_ready=1.
  - res_valid=1 writes buffer[0], sets wr_cnt=1 and moves to COLLECT.
  - If PIPELINE_STAGES=1, it moves directly to DRAIN instead.
- COLLECT:
  - res_ready=1.
  - Each res_valid=1 writes buffer[wr_cnt] and increments wr_cnt.
  - Gaps (res_valid=0) are allowed; state holds.
  - The write that lands on slot PIPELINE_STAGES-1 moves the block to DRAIN on the next edge, with rd_slot=0 and rd_beat=0.
- DRAIN:
  - res_ready=0.
  - m_valid=1 from the first cycle in DRAIN, i.e. the cycle after the last capture (latency 1).
  - m_data = buffer[rd_slot][rd_beat*OUT_WIDTH +: OUT_WIDTH], least-significant word first.
  - Slots are drained in ascending order 0..PIPELINE_STAGES-1.
  - m_slot=rd_slot.
  - m_last=1 when rd_beat=BEATS-1.
- Output handshake:
  - A word transfers when m_valid and m_ready are both 1.
  - While m_ready=0, m_data, m_last and m_slot hold stable and m_valid stays 1.
  - On each transfer rd_beat increments; it wraps to 0 after BEATS-1 and rd_slot increments at that point.
- End of batch:
  - The transfer at rd_slot=PIPELINE_STAGES-1, rd_beat=BEATS-1 returns the block to IDLE on the next edge.
  - batch_done=1 for exactly that next cycle.
  - res_ready=1 in the same cycle, so back-to-back batches are supported.
- Overflow:
  - res_valid=1 while res_ready=0 sets overflow=1 until reset.
  - The offending data is dropped; the buffer and the drain are unaffected.
- m_valid is 0 in IDLE and COLLECT.
- Reset mid-operation: any in-flight batch is discarded; all outputs return to their reset values immediately, asynchronously.
- No combinational path from m_ready to m_valid or to m_data.

Test Plan:
- Basic drain:
  - Stimulus: 8 consecutive res_valid with res_data[k] = {4{64'h(k<<8)+w}} pattern, m_ready=1.
  - Required: first m_valid exactly 1 cycle after the 8th capture; 32 words in order slot0 w0..w3 … slot7 w3; m_last on words 3,7,…,31; batch_done 1 cycle after word 31.
- Backpressure:
  - Stimulus: same batch with m_ready toggling pseudo-randomly, including a 10-cycle stall on slot 3 beat 2.
  - Required: m_data and m_slot=3 held across the stall; no word lost or duplicated; 32 transfers total.
- Gapped input:
  - Stimulus: res_valid with 0–5 idle cycles between results.
  - Required: state stays COLLECT; DRAIN starts only after the 8th result; data order unchanged.
- Overflow:
  - Stimulus: assert res_valid with data 0xDEAD… in the 2nd DRAIN cycle.
  - Required: overflow=1 and stays 1; drained data equals the original batch.
- Back-to-back batches:
  - Stimulus: second batch's first res_valid in the batch_done cycle.
  - Required: it is accepted (res_ready=1); second batch drains correctly; overflow=0.
- Reset mid-drain:
  - Stimulus: rst_n low after word 13 (slot 3, beat 1), then release and send a new batch.
  - Required: outputs at reset values immediately; the new batch drains from slot 0 beat 0.
